// File: rtl/clock_calendar_pkg.sv
// clock_cal_pkg: calendar constants and Gregorian helpers shared by the date stage.
package clock_cal_pkg;

    localparam logic [3:0] JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
                           MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
                           SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12;

    localparam logic [2:0] MON = 3'd0, TUE = 3'd1, WED = 3'd2, THU = 3'd3,
                           FRI = 3'd4, SAT = 3'd5, SUN = 3'd6;

    localparam logic [4:0] DAY_MIN   = 5'd1;
    localparam logic [3:0] MONTH_MAX = 4'd12;

    function automatic logic is_leap(input int unsigned y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    // Out-of-range months fall into the 31-day arm; callers validate month separately.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        return (m == FEB) ? (leap ? 5'd29 : 5'd28) :
               (m == APR || m == JUN || m == SEP || m == NOV) ? 5'd30 : 5'd31;
    endfunction

endpackage

// File: rtl/clock_calendar_if.sv
// clock_calendar_if: date load request with ack/error response.
interface clock_calendar_if #(
    parameter int YEAR_W = 12
);
    logic              set_stb;
    logic [4:0]        set_day;
    logic [3:0]        set_month;
    logic [YEAR_W-1:0] set_year;
    logic [2:0]        set_wday;
    logic              set_ack;
    logic              set_err;

    modport master (output set_stb, set_day, set_month, set_year, set_wday,
                    input  set_ack, set_err);
    modport slave  (input  set_stb, set_day, set_month, set_year, set_wday,
                    output set_ack, set_err);
endinterface

// File: rtl/clock_calendar_days_in_month.sv
// cal_days_in_month: combinational month length for a given month and year.
module cal_days_in_month
    import clock_cal_pkg::*;
#(
    parameter int YEAR_W = 12
)(
    input  logic [3:0]        month_i,
    input  logic [YEAR_W-1:0] year_i,
    output logic [4:0]        dim_o
);
    assign dim_o = days_in_month(month_i, is_leap(32'(year_i)));
endmodule

// File: rtl/clock_calendar.sv
// clock_calendar: day/month/year/weekday counter advanced by day ticks,
// with a validated load port that takes priority over a coincident tick.
module clock_calendar
    import clock_cal_pkg::*;
#(
    parameter int YEAR_W   = 12,
    parameter int YEAR_RST = 2025,
    parameter int WDAY_RST = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              day_tick_i,
    clock_calendar_if.slave   set_if,
    output logic [4:0]        day_o,
    output logic [3:0]        month_o,
    output logic [YEAR_W-1:0] year_o,
    output logic [2:0]        wday_o,
    output logic              month_tick_o,
    output logic              year_tick_o
);
    logic [4:0]        day_q, day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [2:0]        wday_q, wday_d;
    logic              ack_q, ack_d, err_q, err_d, mtick_q, mtick_d, ytick_q, ytick_d;
    logic [4:0]        cur_dim, set_dim;
    logic              set_ok;

    cal_days_in_month #(.YEAR_W(YEAR_W)) u_cur_dim (
        .month_i(month_q), .year_i(year_q), .dim_o(cur_dim)
    );

    // Validation uses the requested year, not the current one.
    cal_days_in_month #(.YEAR_W(YEAR_W)) u_set_dim (
        .month_i(set_if.set_month), .year_i(set_if.set_year), .dim_o(set_dim)
    );

    assign set_ok = set_if.set_month >= JAN && set_if.set_month <= MONTH_MAX &&
                    set_if.set_day >= DAY_MIN && set_if.set_day <= set_dim &&
                    set_if.set_wday <= SUN;

    always_comb begin
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        wday_d  = wday_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mtick_d = 1'b0;
        ytick_d = 1'b0;
        if (set_if.set_stb) begin
            ack_d = 1'b1;
            err_d = !set_ok;
            if (set_ok) begin
                day_d   = set_if.set_day;
                month_d = set_if.set_month;
                year_d  = set_if.set_year;
                wday_d  = set_if.set_wday;
            end
        end else if (day_tick_i) begin
            wday_d = (wday_q == SUN) ? MON : wday_q + 3'd1;
            if (day_q < cur_dim) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d   = DAY_MIN;
                mtick_d = 1'b1;
                ytick_d = (month_q == DEC);
                month_d = (month_q == DEC) ? JAN : month_q + 4'd1;
                year_d  = (month_q == DEC) ? year_q + 1'b1 : year_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            day_q   <= DAY_MIN;
            month_q <= JAN;
            year_q  <= YEAR_W'(YEAR_RST);
            wday_q  <= 3'(WDAY_RST);
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            mtick_q <= 1'b0;
            ytick_q <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            wday_q  <= wday_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mtick_q <= mtick_d;
            ytick_q <= ytick_d;
        end
    end

    assign day_o          = day_q;
    assign month_o        = month_q;
    assign year_o         = year_q;
    assign wday_o         = wday_q;
    assign month_tick_o   = mtick_q;
    assign year_tick_o    = ytick_q;
    assign set_if.set_ack = ack_q;
    assign set_if.set_err = err_q;
endmodule

// File: doc/clock_calendar.md
Name: clock_calendar

Overview:
- Date stage directly downstream of the hours counter.
- Consumes the single-cycle day rollover pulse (hours 23 -> 0) and maintains day-of-month, month, year and weekday with full Gregorian leap-year rules.
- Provides a strobe/ack load port for setting the date, with range validation.
- Outputs feed the display/formatting stage.

Parameters:
- YEAR_W, 12, width of year counter (years 0..2^YEAR_W-1).
- YEAR_RST, 2025, year after reset.
- WDAY_RST, 2, weekday after reset (0=Mon..6=Sun; 1 Jan 2025 = Wed).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- day_tick  input  1  one-cycle pulse: hours wrapped 23->0
- set_stb  input  1  one-cycle load request
- set_day  input  5  requested day, 1..31
- set_month  input  4  requested month, 1..12
- set_year  input  YEAR_W  requested year
- set_wday  input  3  requested weekday, 0..6
- set_ack  output  1  one-cycle pulse, load request processed
- set_err  output  1  valid with set_ack; 1 = request rejected
- day  output  5  current day of month, 1..31
- month  output  4  current month, 1..12
- year  output  YEAR_W  current year
- wday  output  3  current weekday, 0..6
- month_tick  output  1  one-cycle pulse, month advanced by a tick
- year_tick  output  1  one-cycle pulse, year advanced by a tick

Behaviour:
- Reset is synchronous, active-high; clock clk.
  - Values after reset: day=1, month=1, year=YEAR_RST, wday=WDAY_RST.
  - Pulse outputs after reset: set_ack=0, set_err=0, month_tick=0, year_tick=0.
- All outputs are registered.
- Event sampled in cycle N takes effect at the rising edge ending cycle N. New values and any pulse are visible in cycle N+1 only; pulses deassert in N+2.
- Leap year, combinational on a year value:
  - (y mod 4 == 0 and y mod 100 != 0) or y mod 400 == 0.
  - Year 0 is leap.
- Days in month:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 29 or 28 for month 2, by the leap rule.
- On day_tick with no set_stb:
  - wday = (wday==6) ? 0 : wday+1.
  - If day < dim(month,year): day+1.
  - Else if month < 12: day=1, month+1, month_tick=1.
  - Else: day=1, month=1, year+1 (wraps 2^YEAR_W-1 -> 0), month_tick=1, year_tick=1.
- On set_stb, validity checks:
  - set_month in 1..12.
  - set_day in 1..dim(set_month,set_year), computed on the requested year.
  - set_wday <= 6.
  - Valid: load all four fields; set_ack=1, set_err=0.
  - Invalid: no field changes; set_ack=1, set_err=1.
  - month_tick and year_tick are never asserted by a load.
- set_stb and day_tick in the same cycle:
  - Load has priority. The tick is discarded, not deferred.
  - Ack and error follow the load rules above.
- set_stb held high for multiple cycles: each cycle is an independent request with its own ack.
- day_tick arriving back-to-back on consecutive cycles advances on each one. There is no rate limiting.
- Reset mid-operation: pending pulses are cleared, and any strobe or tick in the reset cycle is ignored.
- Illegal state (e.g. day beyond dim) cannot be reached from reset or through validated loads. No recovery logic is required.

Decomposition:
- Package clock_cal_pkg holds:
  - Month constants JAN..DEC.
  - Weekday constants MON..SUN (0..6).
  - Function is_leap(year).
  - Function days_in_month(month, leap).
  - Constants DAY_MIN=1, MONTH_MAX=12.
- One natural sub-module: cal_days_in_month, combinational (month, year -> dim). It is instantiated twice: once for the current date and once for set validation.

Test Plan:
- Reset, then idle 10 cycles -> 1/1/2025, wday=2, all pulses 0.
- Load 31/1/2025 wday 4, then tick -> 1/2/2025, wday=5, month_tick=1 for exactly one cycle, year_tick=0.
- Leap rules:
  - Load 28/2/2024, tick -> 29/2/2024.
  - 28/2/2100, tick -> 1/3/2100.
  - 28/2/2000, tick -> 29/2/2000.
- Year rollover: load 31/12/2025 wday 6, tick -> 1/1/2026, wday=0, month_tick=1 and year_tick=1 in the same cycle.
- Invalid load 30/2/2025 -> set_ack=1, set_err=1, date unchanged. Month 13, day 0 and wday 7 are each rejected in the same way.
- Load 10/5/2025 and day_tick in the same cycle -> 10/5/2025 exactly, set_err=0, no tick effect. Reset asserted during a tick -> reset values.
